// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding and the
// legal ranges of the NPHASE / DIV parameters.
package phase_sequencer_pkg;

  localparam int NPHASE_MIN = 2;
  localparam int NPHASE_MAX = 8;
  localparam int DIV_MIN    = 1;
  localparam int DIV_MAX    = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    STEP = ST_STEP
  } ps_state_e;

endpackage

// File: rtl/phase_sequencer_btn_debounce.sv
// btn_debounce: 2-FF synchroniser followed by a down-counter debouncer.
// The synchronised input must differ from the accepted level for 2^DBW-1
// consecutive clocks before it is taken; 'rise' pulses for one clock when
// the accepted level goes 0->1.
module btn_debounce
  import phase_sequencer_pkg::*;
#(
  parameter int DBW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [1:0]     sync;
  logic           stable;
  logic [DBW-1:0] cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], din};
  end

  // Reload on agreement, count down on disagreement, accept at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '1;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '1;
      end else if (cnt == DBW'(1)) begin
        stable <= sync[1];
        cnt    <= '1;
        rise   <= sync[1];
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: steps an instruction through NPHASE phases of DIV clocks
// each, strobing phase_en at each phase commit and counting retired
// instructions. Optional single-step button support is enabled by defining
// the macro PHASE_STEP_EN.
//
//  state | meaning
//  IDLE  | not sequencing; divider and phase held at 0
//  RUN   | free-running instructions back to back while run=1
//  STEP  | executing exactly one instruction for a step event
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NPHASE = 5,
  parameter int DIV    = 2,
  parameter int DBW    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      stall,
  input  logic                      step_btn,
  output logic [$clog2(NPHASE)-1:0] phase,
  output logic [NPHASE-1:0]         phase_en,
  output logic                      inst_done,
  output logic                      busy,
  output logic [31:0]               retired
);

  localparam int PW = $clog2(NPHASE);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(NPHASE - 1);

  ps_state_e     state;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          last_phase;
  logic          step_evt;

`ifdef PHASE_STEP_EN
  btn_debounce #(.DBW(DBW)) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (step_btn),
    .rise (step_evt)
  );
`else
  // Button is not wired in this build; STEP can never be entered.
  logic unused_step;
  assign unused_step = step_btn ^ DBW[0];
  assign step_evt    = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign tick       = busy & ~stall & (div_cnt == DIV_LAST);
  assign last_phase = (phase == PH_LAST);
  assign inst_done  = tick & last_phase;
  assign phase_en   = tick ? (NPHASE'(1) << phase) : '0;

  // Mode control; stall freezes every transition, including leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (!stall) begin
      case (state)
        IDLE:    if (run)           state <= RUN;
                 else if (step_evt) state <= STEP;
        RUN:     if (inst_done && !run) state <= IDLE;
        STEP:    if (inst_done)         state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clock divider and phase counter; both wrap to 0 at instruction end,
  // which is why they already sit at 0 whenever the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= last_phase ? '0 : phase + 1'b1;
    end else if (busy && !stall) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            retired <= '0;
    else if (inst_done) retired <= retired + 32'd1;
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NPHASE=5, DIV=2, DBW=4): a vector
// table for the run/stall/run-drop flow plus hand-written sequences for the
// long run, counter wrap, mid-instruction reset and the step button.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, stall, step_btn;
  logic [2:0]  phase;
  logic [4:0]  phase_en;
  logic        inst_done, busy;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;
  int unsigned done_cnt = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.NPHASE(5), .DIV(2), .DBW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .stall     (stall),
    .step_btn  (step_btn),
    .phase     (phase),
    .phase_en  (phase_en),
    .inst_done (inst_done),
    .busy      (busy),
    .retired   (retired)
  );

  always @(posedge clk) if (inst_done) done_cnt <= done_cnt + 1;

  typedef struct packed {
    logic        run;
    logic        stall;
    logic        btn;
    logic [2:0]  ph;
    logic [4:0]  en;
    logic        done;
    logic        bsy;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; stall = 1'b0; step_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    bit ok;
    rst = 1'b1; run = 1'b0; stall = 1'b0; step_btn = 1'b0;
    #1;
    check("reset.busy", busy, 0);
    check("reset.phase", phase, 0);
    check("reset.phase_en", phase_en, 0);
    check("reset.retired", retired, 0);

    // run / stall during phase 1 tick / run dropped at phase 2 / stall in IDLE
    //                run stl btn ph  en      dn bsy ret
    tbl.push_back('{1'b0,1'b0,1'b0,3'd0,5'h00,1'b0,1'b0,32'd0});
    tbl.push_back('{1'b1,1'b0,1'b1,3'd0,5'h00,1'b0,1'b0,32'd0});
    tbl.push_back('{1'b1,1'b0,1'b0,3'd0,5'h00,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b1,1'b0,1'b0,3'd0,5'h01,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b1,1'b0,1'b0,3'd1,5'h00,1'b0,1'b1,32'd0});
    for (int i = 0; i < 7; i++)
      tbl.push_back('{1'b1,1'b1,1'b0,3'd1,5'h00,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b1,1'b0,1'b0,3'd1,5'h02,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd2,5'h00,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd2,5'h04,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd3,5'h00,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd3,5'h08,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd4,5'h00,1'b0,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd4,5'h10,1'b1,1'b1,32'd0});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd0,5'h00,1'b0,1'b0,32'd1});
    tbl.push_back('{1'b1,1'b1,1'b0,3'd0,5'h00,1'b0,1'b0,32'd1});
    tbl.push_back('{1'b1,1'b1,1'b0,3'd0,5'h00,1'b0,1'b0,32'd1});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd0,5'h00,1'b0,1'b0,32'd1});
    tbl.push_back('{1'b0,1'b0,1'b0,3'd0,5'h00,1'b0,1'b0,32'd1});

    do_reset();
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      run = tbl[i].run; stall = tbl[i].stall; step_btn = tbl[i].btn;
      #1;
      check($sformatf("vec%0d.phase", i),     phase,     tbl[i].ph);
      check($sformatf("vec%0d.phase_en", i),  phase_en,  tbl[i].en);
      check($sformatf("vec%0d.inst_done", i), inst_done, tbl[i].done);
      check($sformatf("vec%0d.busy", i),      busy,      tbl[i].bsy);
      check($sformatf("vec%0d.retired", i),   retired,   tbl[i].ret);
    end

    // 30 clk of free run: strobe every 2 clk, inst_done at clk 10/20/30
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      int j;
      logic [4:0] exp_en;
      logic exp_done;
      @(negedge clk); #1;
      j = (k / 2 - 1) % 5;
      exp_en   = (k % 2 == 0) ? 5'(1 << j) : 5'h00;
      exp_done = (k % 2 == 0) && (j == 4);
      check($sformatf("run30.k%0d.phase", k), phase, ((k - 1) / 2) % 5);
      check($sformatf("run30.k%0d.phase_en", k), phase_en, exp_en);
      check($sformatf("run30.k%0d.inst_done", k), inst_done, exp_done);
      if (k == 30) run = 1'b0;
    end
    @(negedge clk); #1;
    check("run30.retired", retired, 3);
    check("run30.busy_after", busy, 0);

    // reset asserted at phase 3 aborts the instruction
    do_reset();
    d0 = done_cnt;
    run = 1'b1;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    #1;
    check("rstmid.phase_before", phase, 3);
    rst = 1'b1;
    #1;
    check("rstmid.busy", busy, 0);
    check("rstmid.phase", phase, 0);
    check("rstmid.phase_en", phase_en, 0);
    check("rstmid.inst_done", inst_done, 0);
    check("rstmid.retired", retired, 0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    repeat (12) @(negedge clk);
    check("rstmid.no_done", done_cnt - d0, 0);

    // retired wraps from 0xFFFFFFFF to 0
    do_reset();
    @(negedge clk);
    force dut.retired = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired;
    #1;
    check("wrap.preload", retired, 32'hFFFF_FFFF);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    check("wrap.idle_in_time", ok, 1);
    check("wrap.retired", retired, 0);

`ifdef PHASE_STEP_EN
    // bouncy button press -> one instruction; second press in STEP ignored
    begin
      bit got;
      do_reset();
      d0  = done_cnt;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        step_btn = (i == 1) ? 1'b0 : (i < 20);
        #1;
        if (busy && !got) begin got = 1'b1; stall = 1'b1; end
      end
      check("step.entered", got, 1);
      check("step.retired_before", retired, 0);
      step_btn = 1'b1;
      repeat (25) @(negedge clk);
      step_btn = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("step.stall_phase", phase, 0);
      check("step.stall_en", phase_en, 0);
      stall = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk); #1;
        if (!busy) begin ok = 1'b1; break; end
      end
      check("step.idle_in_time", ok, 1);
      check("step.retired", retired, 1);
      check("step.one_done", done_cnt - d0, 1);
      ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk); #1;
        if (busy) ok = 1'b0;
      end
      check("step.no_second", ok, 1);
    end
`else
    // without step support a held button must never start an instruction
    do_reset();
    ok = 1'b1;
    step_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (busy) ok = 1'b0;
    end
    step_btn = 1'b0;
    check("nostep.idle", ok, 1);
    check("nostep.retired", retired, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter NPHASE, default 5, number of instruction phases (legal 2..8).
REQ-002 SHALL have parameter DIV, default 2, clk cycles per phase (legal 1..16).
REQ-003 SHALL have parameter DBW, default 16, debounce counter width (used only with PHASE_STEP_EN).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port run  input  1  level; 1 = free-run instructions back to back.
REQ-007 SHALL have port stall  input  1  level; 1 = freeze divider and phase.
REQ-008 SHALL have port step_btn  input  1  raw asynchronous single-step button.
REQ-009 SHALL have port phase  output  $clog2(NPHASE)  current phase index.
REQ-010 SHALL have port phase_en  output  NPHASE  one-hot, one-clk phase-commit strobe.
REQ-011 SHALL have port inst_done  output  1  one-clk pulse at commit of last phase.
REQ-012 SHALL have port busy  output  1  1 while in RUN or STEP.
REQ-013 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, STEP.
REQ-015 SHALL go IDLE->RUN when run=1; IDLE->STEP on a qualified step event (REQ-027) while run=0; run takes priority if both occur in the same cycle.
REQ-016 SHALL keep div_cnt (0..DIV-1) and phase counting only in RUN/STEP; in IDLE both hold at 0.
REQ-017 SHALL define tick = busy & ~stall & (div_cnt==DIV-1); on tick div_cnt->0 and phase->phase+1, wrapping NPHASE-1->0; otherwise, when busy and not stalled, div_cnt increments.
REQ-018 SHALL assert phase_en[phase] for exactly the tick cycle; phase_en SHALL be all-zero in every other cycle.
REQ-019 SHALL assert inst_done and increment retired (mod 2^32, 0xFFFFFFFF->0) on a tick with phase==NPHASE-1.
REQ-020 SHALL make instructions atomic: run falling mid-instruction completes the current instruction, then RUN->IDLE on that inst_done; if run is still 1 at inst_done, remain in RUN with no bubble cycle.
REQ-021 SHALL return STEP->IDLE on inst_done, i.e. exactly one instruction per step.
REQ-022 SHALL freeze all state while stall=1, including inside IDLE transitions: no FSM transition, no strobes; stall wins over run deassertion and over tick.
REQ-023 SHALL with DIV=1 produce one tick every unstalled busy clk: NPHASE clk per instruction.
REQ-024 SHALL ignore step events in RUN or STEP (not queued).
REQ-025 SHALL drive busy, phase, and retired combinationally from registers only; no input-to-output combinational path.

Reset
REQ-026 SHALL on rst force state IDLE, div_cnt 0, phase 0, phase_en 0, inst_done 0, busy 0, retired 0, and clear synchroniser/debouncer state; reset mid-instruction SHALL abort it without inst_done.

Configuration
REQ-027 SHALL with PHASE_STEP_EN defined pass step_btn through a 2-FF synchroniser and debouncer (stable for 2^DBW-1 clk), with one step event on the debounced rising edge.
REQ-028 SHALL without PHASE_STEP_EN ignore step_btn, instantiate no synchroniser/debouncer, and make STEP unreachable.

Structure
REQ-029 SHALL place the FSM state enum and the NPHASE/DIV legal-range constants in the shared package.
REQ-030 SHALL implement the synchroniser+debouncer as sub-module btn_debounce (params DBW; ports clk, rst, din, rise), instantiated only under PHASE_STEP_EN.

Verification
REQ-031 SHALL cover: NPHASE=5, DIV=2, run=1 for 30 clk after reset -> phase_en strobes 1,2,4,8,16 every 2 clk, inst_done at clk 10,20,30, retired=3.
REQ-032 SHALL cover: run dropped at phase 2 -> phases 3,4 complete, inst_done once, then IDLE, busy=0, phase=0.
REQ-033 SHALL cover: stall=1 for 7 clk during phase 1 -> no strobes, phase/div_cnt unchanged; sequence resumes exactly after release.
REQ-034 SHALL cover: PHASE_STEP_EN, DBW=4, button held 20 clk with 3-clk bounce at the start -> exactly one instruction, retired 0->1, return to IDLE; second press in STEP ignored.
REQ-035 SHALL cover: retired preloaded via force to 0xFFFFFFFF, one instruction -> retired=0.
REQ-036 SHALL cover: rst asserted at phase 3 of an instruction -> all outputs 0 the same cycle, no inst_done, retired unchanged at 0.
